// File: rtl/xadac_pkg.sv
// xadac_pkg: shared widths, vector register types and the operand-fetch state enum.
package xadac_pkg;
  localparam int VectorWidth = 128;
  localparam int NrVRegs = 32;
  typedef logic [$clog2(NrVRegs)-1:0] vreg_addr_t;
  typedef logic [VectorWidth-1:0] vec_t;
  typedef enum logic [2:0] {OF_IDLE, OF_RD_A, OF_RD_B, OF_RD_C, OF_ISSUE} opfetch_state_e;
endpackage

// File: rtl/xadac_scoreboard.sv
// xadac_scoreboard: pending-writeback bit per vector register with four combinational lookups.
module xadac_scoreboard #(
  parameter int NrVRegs = xadac_pkg::NrVRegs,
  localparam int AW = $clog2(NrVRegs)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                set_valid,
  input  logic [AW-1:0]       set_addr,
  input  logic                clr_valid,
  input  logic [AW-1:0]       clr_addr,
  input  logic [3:0][AW-1:0]  lookup_addr,
  output logic [3:0]          lookup_hit
);
  logic [NrVRegs-1:0] pending;
  // set is applied after clear so it wins on a collision
  always_ff @(posedge clk) begin
    if (!rstn) pending <= '0;
    else pending <= (pending & ~(NrVRegs'(clr_valid) << clr_addr)) | (NrVRegs'(set_valid) << set_addr);
  end
  for (genvar i = 0; i < 4; i++) begin : g_lookup
    assign lookup_hit[i] = pending[lookup_addr[i]];
  end
endmodule

// File: rtl/xadac_operand_fetch.sv
// xadac_operand_fetch: reads vs1/vs2/vs3 over two VRF ports and issues one instruction to execution.
// XADAC_OPFETCH_SCOREBOARD_EN compiles in the RAW/WAW scoreboard and hazard stalling.
module xadac_operand_fetch import xadac_pkg::*; #(
  parameter int NrVRegs = xadac_pkg::NrVRegs,
  parameter int IdWidth = 4,
  parameter int ImmWidth = 32,
  localparam int AW = $clog2(NrVRegs)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [IdWidth-1:0]  dec_id,
  input  logic [AW-1:0]       dec_vs1,
  input  logic [AW-1:0]       dec_vs2,
  input  logic [AW-1:0]       dec_vs3,
  input  logic [AW-1:0]       dec_vd,
  input  logic                dec_use_vs3,
  input  logic [ImmWidth-1:0] dec_imm,
  output logic [AW-1:0]       vrf_raddr0,
  output logic [AW-1:0]       vrf_raddr1,
  input  vec_t                vrf_rdata0,
  input  vec_t                vrf_rdata1,
  output logic                ex_req_valid,
  input  logic                ex_req_ready,
  output logic [IdWidth-1:0]  ex_req_id,
  output logic [AW-1:0]       ex_req_vd,
  output logic [ImmWidth-1:0] ex_req_imm,
  output vec_t                ex_req_vs1,
  output vec_t                ex_req_vs2,
  output vec_t                ex_req_vs3,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_addr
);
  opfetch_state_e state, state_nxt;
  logic [IdWidth-1:0] id_q;
  logic [AW-1:0] vs1_q, vs2_q, vs3_q, vd_q;
  logic use_vs3_q;
  logic [ImmWidth-1:0] imm_q;
  vec_t op1_q, op2_q, op3_q;
  logic hazard, dec_hs;
  always_ff @(posedge clk) begin
    if (!rstn) state <= OF_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      OF_IDLE:  state_nxt = dec_hs ? OF_RD_A : OF_IDLE;
      OF_RD_A:  state_nxt = OF_RD_B;
      OF_RD_B:  state_nxt = use_vs3_q ? OF_RD_C : OF_ISSUE;
      OF_RD_C:  state_nxt = OF_ISSUE;
      OF_ISSUE: state_nxt = !ex_req_ready ? OF_ISSUE : dec_hs ? OF_RD_A : OF_IDLE;
      default:  state_nxt = OF_IDLE;
    endcase
  end
  always_comb begin
    ex_req_valid = state == OF_ISSUE;
    dec_ready = (state == OF_IDLE || (ex_req_valid && ex_req_ready)) && !hazard;
    dec_hs = dec_valid && dec_ready;
    vrf_raddr0 = state == OF_RD_A ? vs1_q : state == OF_RD_B ? vs3_q : '0;
    vrf_raddr1 = state == OF_RD_A ? vs2_q : '0;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      {id_q, vs1_q, vs2_q, vs3_q, vd_q, use_vs3_q, imm_q} <= '0;
      {op1_q, op2_q, op3_q} <= '0;
    end else begin
      if (dec_hs) {id_q, vs1_q, vs2_q, vs3_q, vd_q, use_vs3_q, imm_q} <=
        {dec_id, dec_vs1, dec_vs2, dec_vs3, dec_vd, dec_use_vs3, dec_imm};
      if (state == OF_RD_B) {op1_q, op2_q, op3_q} <= {vrf_rdata0, vrf_rdata1, {$bits(vec_t){1'b0}}};
      if (state == OF_RD_C) op3_q <= vrf_rdata0;
    end
  end
  assign ex_req_id = id_q;
  assign ex_req_vd = vd_q;
  assign ex_req_imm = imm_q;
  assign ex_req_vs1 = op1_q;
  assign ex_req_vs2 = op2_q;
  assign ex_req_vs3 = op3_q;
`ifdef XADAC_OPFETCH_SCOREBOARD_EN
  logic [3:0][AW-1:0] look;
  logic [3:0] hit, issuing;
  assign look = {dec_vd, dec_vs3, dec_vs2, dec_vs1};
  for (genvar i = 0; i < 4; i++) begin : g_issuing
    assign issuing[i] = ex_req_valid && look[i] == vd_q;
  end
  // the vd leaving in ISSUE is treated as already pending
  assign hazard = |((hit | issuing) & {1'b1, dec_use_vs3, 2'b11});
  xadac_scoreboard #(.NrVRegs(NrVRegs)) i_scoreboard (
    .clk(clk),
    .rstn(rstn),
    .set_valid(ex_req_valid && ex_req_ready),
    .set_addr(vd_q),
    .clr_valid(wb_valid),
    .clr_addr(wb_addr),
    .lookup_addr(look),
    .lookup_hit(hit)
  );
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_addr};
  assign hazard = 1'b0;
`endif
endmodule

// File: tb/tb_xadac_operand_fetch.sv
// tb_xadac_operand_fetch: directed plan plus random traffic checked against a transaction-level model.
module tb_xadac_operand_fetch;
  import xadac_pkg::*;
  localparam int NR = 32, IW = 4, MW = 32, AW = 5;
  logic clk = 1'b0, rstn = 1'b0;
  logic dec_valid = 1'b0, dec_ready, dec_use_vs3 = 1'b0;
  logic [IW-1:0] dec_id = '0;
  logic [AW-1:0] dec_vs1 = '0, dec_vs2 = '0, dec_vs3 = '0, dec_vd = '0;
  logic [MW-1:0] dec_imm = '0;
  logic [AW-1:0] vrf_raddr0, vrf_raddr1;
  vec_t vrf_rdata0 = '0, vrf_rdata1 = '0;
  logic ex_req_valid, ex_req_ready = 1'b1;
  logic [IW-1:0] ex_req_id;
  logic [AW-1:0] ex_req_vd;
  logic [MW-1:0] ex_req_imm;
  vec_t ex_req_vs1, ex_req_vs2, ex_req_vs3;
  logic wb_valid = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  vec_t vrf [NR];
  bit m_busy, m_use3, m_ok;
  int m_age;
  bit [IW-1:0] m_id;
  bit [AW-1:0] m_vs1, m_vs2, m_vs3, m_vd;
  bit [MW-1:0] m_imm;
  bit m_pend [NR];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    vrf_rdata0 <= vrf[vrf_raddr0];
    vrf_rdata1 <= vrf[vrf_raddr1];
  end
  xadac_operand_fetch #(.NrVRegs(NR), .IdWidth(IW), .ImmWidth(MW)) dut (
    .clk(clk), .rstn(rstn), .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_id(dec_id),
    .dec_vs1(dec_vs1), .dec_vs2(dec_vs2), .dec_vs3(dec_vs3), .dec_vd(dec_vd),
    .dec_use_vs3(dec_use_vs3), .dec_imm(dec_imm), .vrf_raddr0(vrf_raddr0), .vrf_raddr1(vrf_raddr1),
    .vrf_rdata0(vrf_rdata0), .vrf_rdata1(vrf_rdata1), .ex_req_valid(ex_req_valid),
    .ex_req_ready(ex_req_ready), .ex_req_id(ex_req_id), .ex_req_vd(ex_req_vd), .ex_req_imm(ex_req_imm),
    .ex_req_vs1(ex_req_vs1), .ex_req_vs2(ex_req_vs2), .ex_req_vs3(ex_req_vs3),
    .wb_valid(wb_valid), .wb_addr(wb_addr)
  );
  function automatic vec_t rep(input logic [7:0] b);
    return {VectorWidth/8{b}};
  endfunction
  task automatic chk(input string name, input logic [VectorWidth-1:0] act, input logic [VectorWidth-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic bit m_valid();
    return m_busy && m_age >= (m_use3 ? 4 : 3);
  endfunction
  function automatic bit m_hazard();
    bit h = 0;
`ifdef XADAC_OPFETCH_SCOREBOARD_EN
    bit [AW-1:0] a [4];
    a = '{dec_vs1, dec_vs2, dec_vs3, dec_vd};
    for (int k = 0; k < 4; k++)
      if ((k != 2 || dec_use_vs3) && (m_pend[a[k]] || (m_valid() && a[k] == m_vd))) h = 1;
`endif
    return h;
  endfunction
  function automatic bit m_dec_ready();
    return (!m_busy || (m_valid() && ex_req_ready)) && !m_hazard();
  endfunction
  task automatic cycle();
    bit v, dr;
    #1;
    v = m_valid();
    dr = m_dec_ready();
    if (m_ok) begin
      chk("ex_req_valid", ex_req_valid, v);
      chk("dec_ready", dec_ready, dr);
      chk("vrf_raddr0", vrf_raddr0, (m_busy && m_age == 1) ? m_vs1 : (m_busy && m_age == 2) ? m_vs3 : 0);
      chk("vrf_raddr1", vrf_raddr1, (m_busy && m_age == 1) ? m_vs2 : 0);
      if (v) begin
        chk("ex_req_id", ex_req_id, m_id);
        chk("ex_req_vd", ex_req_vd, m_vd);
        chk("ex_req_imm", ex_req_imm, m_imm);
        chk("ex_req_vs1", ex_req_vs1, vrf[m_vs1]);
        chk("ex_req_vs2", ex_req_vs2, vrf[m_vs2]);
        chk("ex_req_vs3", ex_req_vs3, m_use3 ? vrf[m_vs3] : '0);
      end
    end
    @(posedge clk);
    if (!rstn) begin
      m_busy = 0;
      m_pend = '{default: 0};
      m_ok = 1;
    end else begin
      if (wb_valid) m_pend[wb_addr] = 0;
      if (v && ex_req_ready) m_pend[m_vd] = 1;
      if (dec_valid && dr) begin
        {m_id, m_vs1, m_vs2, m_vs3, m_vd, m_use3, m_imm} = {dec_id, dec_vs1, dec_vs2, dec_vs3, dec_vd, dec_use_vs3, dec_imm};
        m_busy = 1;
        m_age = 1;
      end else if (v && ex_req_ready) m_busy = 0;
      else if (m_busy) m_age++;
    end
    @(negedge clk);
  endtask
  task automatic set_dec(input bit v, input int vs1, input int vs2, input int vs3, input int vd, input bit u, input int imm);
    dec_valid = v;
    dec_id = IW'(vd + 1);
    {dec_vs1, dec_vs2, dec_vs3, dec_vd} = {AW'(vs1), AW'(vs2), AW'(vs3), AW'(vd)};
    dec_use_vs3 = u;
    dec_imm = MW'(imm);
  endtask
  task automatic do_reset();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    wb_valid = 0;
    ex_req_ready = 1;
    rstn = 0;
    cycle();
    rstn = 1;
    #1;
    chk("rst_dec_ready", dec_ready, 1);
    chk("rst_valid", ex_req_valid, 0);
    chk("rst_payload", {ex_req_id, ex_req_vd, ex_req_imm}, 0);
    chk("rst_ops", ex_req_vs1 | ex_req_vs2 | ex_req_vs3, 0);
    chk("rst_raddr", {vrf_raddr0, vrf_raddr1}, 0);
  endtask
  initial begin
    for (int i = 0; i < NR; i++) vrf[i] = rep(8'(i * 17));
    @(negedge clk);
    // single instruction with vs3: valid exactly in cycle 4
    do_reset();
    set_dec(1, 1, 2, 3, 4, 1, 5);
    cycle();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("lat4_valid", ex_req_valid, k == 4);
      if (k == 4) begin
        chk("lat4_vs1", ex_req_vs1, rep(8'h11));
        chk("lat4_vs2", ex_req_vs2, rep(8'h22));
        chk("lat4_vs3", ex_req_vs3, rep(8'h33));
        chk("lat4_vd_imm", {ex_req_vd, ex_req_imm}, {5'd4, 32'd5});
      end
      cycle();
    end
    // no vs3: valid in cycle 3 with zero third operand
    do_reset();
    set_dec(1, 1, 2, 3, 4, 0, 5);
    cycle();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk("lat3_valid", ex_req_valid, k == 3);
      if (k == 3) chk("lat3_vs3", ex_req_vs3, 0);
      cycle();
    end
    // backpressure then back-to-back accept on release
    do_reset();
    set_dec(1, 1, 2, 3, 4, 1, 5);
    cycle();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    set_dec(1, 5, 6, 0, 8, 0, 9);
    ex_req_ready = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", ex_req_valid, 1);
      chk("bp_dec_ready", dec_ready, 0);
      chk("bp_vs1", ex_req_vs1, rep(8'h11));
      cycle();
    end
    ex_req_ready = 1;
    #1;
    chk("bp_release_ready", dec_ready, 1);
    cycle();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("b2b_valid", ex_req_valid, 0);
    chk("b2b_raddr0", vrf_raddr0, 5);
    repeat (4) cycle();
    // RAW hazard against an issued vd
    do_reset();
    set_dec(1, 1, 2, 3, 4, 1, 5);
    cycle();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    repeat (4) cycle();
    set_dec(1, 4, 5, 0, 9, 0, 1);
`ifdef XADAC_OPFETCH_SCOREBOARD_EN
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("raw_stall", dec_ready, 0);
      cycle();
    end
    wb_valid = 1;
    wb_addr = 4;
    #1;
    chk("raw_no_bypass", dec_ready, 0);
    cycle();
    wb_valid = 0;
`endif
    #1;
    chk("raw_accept", dec_ready, 1);
    cycle();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    // simultaneous set and clear of register 7
    do_reset();
    set_dec(1, 1, 2, 3, 7, 0, 2);
    cycle();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    repeat (2) cycle();
    wb_valid = 1;
    wb_addr = 7;
    cycle();
    wb_valid = 0;
    set_dec(1, 7, 1, 0, 10, 0, 3);
    #1;
`ifdef XADAC_OPFETCH_SCOREBOARD_EN
    chk("setclr_pending", dec_ready, 0);
`else
    chk("setclr_pending", dec_ready, 1);
`endif
    cycle();
    // reset while in RD_B
    do_reset();
    set_dec(1, 1, 2, 3, 4, 1, 5);
    cycle();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    cycle();
    rstn = 0;
    cycle();
    rstn = 1;
    #1;
    chk("midrst_valid", ex_req_valid, 0);
    chk("midrst_ready", dec_ready, 1);
    cycle();
    #1;
    chk("midrst_raddr0", vrf_raddr0, 0);
    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      set_dec($urandom_range(0, 9) < 6, $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom), int'($urandom));
      ex_req_ready = $urandom_range(0, 9) < 7;
      wb_valid = $urandom_range(0, 9) < 4;
      wb_addr = AW'($urandom_range(0, 15));
      rstn = $urandom_range(0, 299) != 0;
      cycle();
    end
    rstn = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
